// File: rtl/console_uart.sv
// Memory-mapped console: STDOUT writes queue bytes for an 8N1 transmitter, TERMINATE latches a sticky halt.
// Status reads return on the next edge; writes to a full FIFO are dropped and flagged as overflow.
module console_uart #(
    parameter int          CLKS_PER_BIT = 8,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [23:0] ADDR_STATUS  = 24'hFFFFFD,
    parameter logic [23:0] ADDR_DATA    = 24'hFFFFFE,
    parameter logic [23:0] ADDR_HALT    = 24'hFFFFFF
) (
    input  logic        i_clk,
    input  logic        i_rstb,
    input  logic        i_clk_en,
    input  logic [23:0] i_daddr,
    input  logic [31:0] i_dout,
    input  logic        i_wr,
    input  logic        i_rd,
    output logic [31:0] o_rdata,
    output logic        o_tx,
    output logic        o_halt,
    output logic        o_irq_empty
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]       BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    tx_state_e        state_q, state_d;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [15:0]      clk_cnt_q, clk_cnt_d;
    logic             tx_q, tx_d;
    logic             halt_q, halt_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      rdata_q, rdata_d;

    logic wr_data, wr_halt, rd_status;
    logic fifo_empty, fifo_full, push, pop, idle_empty, bit_done;
    logic unused_dout;

    assign unused_dout = ^i_dout[31:8];

    assign wr_data    = i_wr && (i_daddr == ADDR_DATA);
    assign wr_halt    = i_wr && (i_daddr == ADDR_HALT);
    assign rd_status  = i_rd && (i_daddr == ADDR_STATUS);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign push       = wr_data && !fifo_full;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign idle_empty = fifo_empty && (state_q == ST_IDLE);
    assign bit_done   = (clk_cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        clk_cnt_d = clk_cnt_q;
        tx_d      = tx_q;
        halt_d    = halt_q | wr_halt;
        ovf_d     = ovf_q;
        rdata_d   = rdata_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // An overflowing write wins over the clearing status read.
        if (wr_data && fifo_full) ovf_d = 1'b1;
        else if (rd_status)       ovf_d = 1'b0;

        if (i_rd) begin
            rdata_d = rd_status
                    ? {16'h0, 8'(cnt_q), 4'h0, halt_q, ovf_q, fifo_full, idle_empty}
                    : 32'h0;
        end

        // tx_d follows the pre-edge state, so the line lags the FSM by one edge.
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d   = fifo_mem[rd_ptr_q];
                    bit_idx_d = 3'd0;
                    clk_cnt_d = 16'd0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    clk_cnt_d = 16'd0;
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    clk_cnt_d = 16'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    clk_cnt_d = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            shift_q   <= 8'h0;
            bit_idx_q <= 3'd0;
            clk_cnt_q <= 16'd0;
            tx_q      <= 1'b1;
            halt_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rdata_q   <= 32'h0;
        end else if (i_clk_en) begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            clk_cnt_q <= clk_cnt_d;
            tx_q      <= tx_d;
            halt_q    <= halt_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge i_clk) begin
        if (i_clk_en && push) fifo_mem[wr_ptr_q] <= i_dout[7:0];
    end

    assign o_rdata     = rdata_q;
    assign o_tx        = tx_q;
    assign o_halt      = halt_q;
    assign o_irq_empty = idle_empty;

endmodule

// File: tb/tb_console_uart.sv
// Directed bench for console_uart: bus writes/reads plus a free-running 8N1 frame monitor.
module tb_console_uart;

    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;
    localparam logic [23:0] A_STAT = 24'hFFFFFD;
    localparam logic [23:0] A_DATA = 24'hFFFFFE;
    localparam logic [23:0] A_HALT = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        clk_en = 1'b1;
    logic [23:0] daddr = 24'h0;
    logic [31:0] dout = 32'h0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] rdata;
    logic        tx, halt, irq_empty;

    int n_chk = 0;
    int n_err = 0;
    bit toggle_en = 1'b0;

    logic [8:0]  rx_q[$];
    int          hold_viol = 0;
    int          mpos = -1;
    logic [39:0] mw;
    logic        mprev = 1'b1;
    logic        men;

    console_uart #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_STATUS (A_STAT),
        .ADDR_DATA   (A_DATA),
        .ADDR_HALT   (A_HALT)
    ) dut (
        .i_clk      (clk),
        .i_rstb     (rstb),
        .i_clk_en   (clk_en),
        .i_daddr    (daddr),
        .i_dout     (dout),
        .i_wr       (wr),
        .i_rd       (rd),
        .o_rdata    (rdata),
        .o_tx       (tx),
        .o_halt     (halt),
        .o_irq_empty(irq_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Frame monitor: one sample per enabled edge, 40 samples per frame.
    initial begin
        forever begin
            @(posedge clk);
            men = clk_en;
            #1;
            if (!rstb) begin
                mpos  = -1;
                mprev = tx;
                continue;
            end
            if (!men) begin
                if (tx !== mprev) hold_viol++;
                mprev = tx;
                continue;
            end
            mprev = tx;
            if (mpos < 0) begin
                if (tx === 1'b0) begin
                    mw[0] = 1'b0;
                    mpos  = 1;
                end
            end else begin
                mw[mpos] = tx;
                mpos++;
                if (mpos == 40) begin
                    logic ok;
                    logic [7:0] b;
                    ok = (mw[0] === 1'b0) && (mw[36] === 1'b1);
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < CPB; j++)
                            if (mw[k*CPB+j] !== mw[k*CPB]) ok = 1'b0;
                    for (int k = 0; k < 8; k++) b[k] = mw[(k+1)*CPB];
                    rx_q.push_back({ok, b});
                    mpos = -1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_en) clk_en = ~clk_en;
    endtask

    task automatic step_en();
        logic was;
        do begin
            was = clk_en;
            step();
        end while (!was);
    endtask

    task automatic cpu_write(input logic [23:0] a, input logic [31:0] d);
        daddr = a;
        dout  = d;
        wr    = 1'b1;
        step_en();
        wr    = 1'b0;
    endtask

    task automatic cpu_read(input logic [23:0] a, output logic [31:0] v);
        daddr = a;
        rd    = 1'b1;
        step_en();
        rd    = 1'b0;
        v     = rdata;
    endtask

    task automatic wait_idle(input int bound, output int t);
        t = 0;
        while (irq_empty !== 1'b1 && t < bound) begin
            step_en();
            t++;
        end
        if (irq_empty !== 1'b1) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        got = 32'hFFFF_FFFF;
        if (rx_q.size() > 0) got = {23'h0, rx_q.pop_front()};
        chk(tag, got, {23'h0, 1'b1, exp});
    endtask

    initial begin
        logic [31:0] v;
        int t;

        // Reset state
        repeat (3) step();
        chk("rst_tx", {31'h0, tx}, 32'd1);
        chk("rst_halt", {31'h0, halt}, 32'd0);
        chk("rst_irq", {31'h0, irq_empty}, 32'd1);
        chk("rst_rdata", rdata, 32'h0);
        rstb = 1'b1;
        step();
        cpu_read(A_STAT, v);
        chk("rst_status", v, 32'h0000_0001);

        // Single byte 0x41: line falls two edges after the write edge, 40-clock frame
        cpu_write(A_DATA, 32'h0000_0041);
        step();
        chk("tx_e2_high", {31'h0, tx}, 32'd1);
        chk("irq_busy", {31'h0, irq_empty}, 32'd0);
        step();
        chk("tx_e3_low", {31'h0, tx}, 32'd0);
        wait_idle(100, t);
        chk("frame_len", t, 32'd39);
        step();
        chk("rx_0x41_n", rx_q.size(), 32'd1);
        chk_rx("rx_0x41", 8'h41);
        cpu_read(A_STAT, v);
        chk("status_idle", v, 32'h0000_0001);

        // Burst of six into a 4-deep FIFO: 0x30 popped early, 0x35 dropped
        for (int i = 0; i < 6; i++) cpu_write(A_DATA, 32'h30 + i);
        cpu_read(A_STAT, v);
        chk("burst_status1", v, 32'h0000_0406);
        cpu_read(A_STAT, v);
        chk("burst_status2", v, 32'h0000_0402);
        cpu_read(A_DATA, v);
        chk("nonmatch_read", v, 32'h0);
        wait_idle(400, t);
        step();
        chk("burst_n", rx_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) chk_rx("burst_byte", 8'h30 + 8'(i));
        cpu_read(A_STAT, v);
        chk("burst_status3", v, 32'h0000_0001);

        // Halt mid-frame: frame completes, later pushes still drain
        cpu_write(A_DATA, 32'h0000_0055);
        repeat (10) step();
        cpu_write(A_HALT, 32'h0000_DEAD);
        chk("halt_set", {31'h0, halt}, 32'd1);
        wait_idle(100, t);
        step();
        chk_rx("halt_frame", 8'h55);
        cpu_read(A_STAT, v);
        chk("halt_status", v, 32'h0000_0009);
        cpu_write(A_DATA, 32'h0000_000F);
        wait_idle(100, t);
        step();
        chk_rx("post_halt", 8'h0F);

        // Clock enable toggling every edge stretches bits to 4 enabled edges
        toggle_en = 1'b1;
        cpu_write(A_DATA, 32'h0000_00A5);
        wait_idle(100, t);
        step_en();
        toggle_en = 1'b0;
        clk_en = 1'b1;
        step();
        chk_rx("clk_en_frame", 8'hA5);
        chk("clk_en_hold", hold_viol, 32'd0);

        // Async reset during DATA bit 3 of 0x30 (bit3 = 0), second byte queued
        cpu_write(A_DATA, 32'h0000_0030);
        cpu_write(A_DATA, 32'h0000_005A);
        repeat (18) step();
        chk("pre_rst_tx", {31'h0, tx}, 32'd0);
        rstb = 1'b0;
        #1;
        chk("async_rst_tx", {31'h0, tx}, 32'd1);
        chk("async_rst_irq", {31'h0, irq_empty}, 32'd1);
        chk("rst_halt_clr", {31'h0, halt}, 32'd0);
        repeat (2) step();
        rstb = 1'b1;
        step();
        cpu_read(A_STAT, v);
        chk("post_rst_status", v, 32'h0000_0001);
        repeat (60) step();
        chk("post_rst_frames", rx_q.size(), 32'd0);
        chk("post_rst_tx", {31'h0, tx}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
